// File: rtl/round_control_if.sv
// Bundle of per-frame game signals between the timing/death logic and round control.
// The master drives sync and hit levels; the slave returns round status.
interface round_control_if;
    logic       vsync_in;
    logic       dead_L;
    logic       dead_R;
    logic       pos_reset;
    logic       freeze;
    logic [2:0] score_L;
    logic [2:0] score_R;
    logic [1:0] winner;
    logic [1:0] state_out;

    modport master (
        output vsync_in, dead_L, dead_R,
        input  pos_reset, freeze, score_L, score_R, winner, state_out
    );

    modport slave (
        input  vsync_in, dead_L, dead_R,
        output pos_reset, freeze, score_L, score_R, winner, state_out
    );
endinterface

// File: rtl/round_control.sv
// Match sequencer: scores kills, freezes play for a number of frames after each kill,
// pulses a position reset on respawn and latches the winner when the match ends.
module round_control #(
    parameter int RESPAWN_FRAMES = 60,
    parameter int WIN_SCORE      = 5
) (
    input  logic            clk,
    input  logic            reset,
    round_control_if.slave  bus
);

    typedef enum logic [1:0] {
        FIGHT     = 2'b00,
        DEAD_WAIT = 2'b01,
        RESPAWN   = 2'b10,
        GAME_OVER = 2'b11
    } state_t;

    typedef struct packed {
        logic       pos_reset;
        logic       freeze;
        logic [2:0] score_L;
        logic [2:0] score_R;
        logic [1:0] winner;
    } status_t;

    localparam logic [7:0] CNT_LAST = 8'(RESPAWN_FRAMES - 1);
    localparam logic [2:0] WIN      = 3'(WIN_SCORE);

    state_t     state_q, state_d;
    status_t    stat_q, stat_d;
    logic [7:0] cnt_q, cnt_d;
    logic       vsync_q;
    logic       tick;

    assign tick = bus.vsync_in & ~vsync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FIGHT;
            stat_q  <= '0;
            cnt_q   <= '0;
            vsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
            vsync_q <= bus.vsync_in;
        end
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        cnt_d   = cnt_q;

        case (state_q)
            FIGHT: begin
                if (bus.dead_L || bus.dead_R) begin
                    state_d = DEAD_WAIT;
                    cnt_d   = '0;
                    // A double KO enters the freeze but credits nobody.
                    if (bus.dead_L && !bus.dead_R && stat_q.score_R < WIN)
                        stat_d.score_R = stat_q.score_R + 3'd1;
                    if (bus.dead_R && !bus.dead_L && stat_q.score_L < WIN)
                        stat_d.score_L = stat_q.score_L + 3'd1;
                end
            end
            DEAD_WAIT: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) state_d = RESPAWN;
                    else                   cnt_d   = cnt_q + 8'd1;
                end
            end
            RESPAWN: begin
                if (stat_q.score_L == WIN || stat_q.score_R == WIN) begin
                    state_d       = GAME_OVER;
                    stat_d.winner = (stat_q.score_L == WIN) ? 2'b01 : 2'b10;
                end else begin
                    state_d = FIGHT;
                end
            end
            default: state_d = GAME_OVER;
        endcase

        // Flags are registered from the next state so they line up with state_out.
        stat_d.freeze    = (state_d != FIGHT);
        stat_d.pos_reset = (state_d == RESPAWN);
    end

    assign bus.pos_reset = stat_q.pos_reset;
    assign bus.freeze    = stat_q.freeze;
    assign bus.score_L   = stat_q.score_L;
    assign bus.score_R   = stat_q.score_R;
    assign bus.winner    = stat_q.winner;
    assign bus.state_out = state_q;

endmodule
